dual_io_uart_arbiter: RTL and testbench

//   Shares the single UART emitter and the halt mailbox between the two IO lanes (A, B) of the dual-issue torv32.

---
 rtl/uart_arb_pkg.sv | 43 ++++
 rtl/uart_arb_fifo.sv | 63 ++++++
 rtl/dual_io_uart_arbiter.sv | 136 +++++++++++++
 tb/tb_dual_io_uart_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants and types for the dual-lane UART arbiter: IO word decode bits,
// status bit positions, the emitter FSM states and the IO read mux.
package uart_arb_pkg;

    localparam int IO_UART_DAT = 1;
    localparam int IO_UART_CTL = 2;
    localparam int IO_HALT     = 3;
    localparam int IO_STATS    = 4;

    localparam int ST_FULL  = 9;
    localparam int ST_OVF   = 1;
    localparam int ST_EMPTY = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2,
        WAIT = 2'd3
    } arb_state_e;

    function automatic logic [31:0] status_word(input logic full,
                                                input logic ovf,
                                                input logic empty);
        logic [31:0] w;
        w           = '0;
        w[ST_FULL]  = full;
        w[ST_OVF]   = ovf;
        w[ST_EMPTY] = empty;
        return w;
    endfunction

    // One-hot word decode: each selected word ORs its value onto the bus.
    function automatic logic [31:0] io_read(input logic [13:0] word,
                                            input logic [31:0] status,
                                            input logic [31:0] stats);
        logic [31:0] r;
        r = '0;
        if (word[IO_UART_CTL]) r = r | status;
        if (word[IO_STATS])    r = r | stats;
        return r;
    endfunction

endpackage

// File: rtl/uart_arb_fifo.sv
// Two-write / one-read character FIFO. Lane A is always written ahead of lane B;
// when only one slot is free, A wins and B is refused (acc_b low).
module uart_arb_fifo
    import uart_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_a,
    input  logic [7:0]    data_a,
    input  logic          push_b,
    input  logic [7:0]    data_b,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          acc_a,
    output logic          acc_b
);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_b_ptr;
    logic [CW-1:0] count_q, count_d, free;
    logic          pop_ok;

    assign pop_ok = pop & ~empty;
    // A same-cycle pop frees the head slot, so a full FIFO can still take one push.
    assign free   = CW'(DEPTH) - count_q + CW'(pop_ok);
    assign acc_a  = push_a & (free != '0);
    assign acc_b  = push_b & (free > CW'(acc_a));

    assign wr_b_ptr = wr_ptr_q + PW'(acc_a);
    assign wr_ptr_d = wr_ptr_q + PW'(acc_a) + PW'(acc_b);
    assign rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    assign count_d  = count_q + CW'(acc_a) + CW'(acc_b) - CW'(pop_ok);

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_ff @(posedge clk) begin
        if (acc_a) mem_q[wr_ptr_q] <= data_a;
        if (acc_b) mem_q[wr_b_ptr] <= data_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dual_io_uart_arbiter.sv
// Shares one UART emitter and the halt mailbox between IO lanes A and B.
// Define UART_ARB_STATS_EN to add a sent-character counter readable at word[4].
module dual_io_uart_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int HOLDOFF = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_io_wr,
    input  logic [31:0] a_io_addr,
    input  logic [31:0] a_io_wdata,
    output logic [31:0] a_io_rdata,
    input  logic        b_io_wr,
    input  logic [31:0] b_io_addr,
    input  logic [31:0] b_io_wdata,
    output logic [31:0] b_io_rdata,
    output logic        uart_valid,
    output logic [7:0]  uart_data,
    input  logic        uart_ready,
    output logic        halt,
    output logic [7:0]  leds
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    arb_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [13:0]   a_word, b_word;
    logic          a_push, b_push, halt_wr, acc_a, acc_b;
    logic          fifo_full, fifo_empty, pop;
    logic [7:0]    head;
    logic [CW-1:0] fifo_count;
    logic          ovf_q, ovf_d, halt_pend_q, halt_pend_d, halt_q, halt_d;
    logic [7:0]    leds_q, leds_d;
    logic [31:0]   status, stats_val;

    assign a_word  = a_io_addr[15:2];
    assign b_word  = b_io_addr[15:2];
    assign a_push  = a_io_wr & a_word[IO_UART_DAT];
    assign b_push  = b_io_wr & b_word[IO_UART_DAT];
    assign halt_wr = (a_io_wr & a_word[IO_HALT]) | (b_io_wr & b_word[IO_HALT]);

    uart_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_a (a_push),
        .data_a (a_io_wdata[7:0]),
        .push_b (b_push),
        .data_b (b_io_wdata[7:0]),
        .pop    (pop),
        .head   (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .acc_a  (acc_a),
        .acc_b  (acc_b)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        uart_valid = 1'b0;
        uart_data  = 8'h00;
        pop        = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty && uart_ready) state_d = SEND;
            SEND: begin
                uart_valid = 1'b1;
                uart_data  = head;
                pop        = 1'b1;
                hold_d     = HW'(HOLDOFF - 1);
                state_d    = HOLD;
            end
            HOLD: begin
                if (hold_q == '0) state_d = WAIT;
                else              hold_d  = hold_q - 1'b1;
            end
            WAIT:    if (uart_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d       = ovf_q | (a_push & ~acc_a) | (b_push & ~acc_b);
        halt_pend_d = halt_pend_q | halt_wr;
        // A push in the deciding cycle must drain first, so it blocks halt.
        halt_d      = halt_q | (halt_pend_q & fifo_empty & (state_q == IDLE) &
                                uart_ready & ~a_push & ~b_push);
        leds_d      = leds_q;
        if (acc_b)      leds_d = b_io_wdata[7:0];
        else if (acc_a) leds_d = a_io_wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            ovf_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            halt_q      <= 1'b0;
            leds_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ovf_q       <= ovf_d;
            halt_pend_q <= halt_pend_d;
            halt_q      <= halt_d;
            leds_q      <= leds_d;
        end
    end

`ifdef UART_ARB_STATS_EN
    logic [31:0] stats_q, stats_d;

    assign stats_d = (state_q == SEND) ? stats_q + 32'd1 : stats_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stats_q <= '0;
        else       stats_q <= stats_d;
    end

    assign stats_val = stats_q;
`else
    assign stats_val = '0;
`endif

    assign status     = status_word(fifo_full, ovf_q, fifo_empty);
    assign a_io_rdata = io_read(a_word, status, stats_val);
    assign b_io_rdata = io_read(b_word, status, stats_val);
    assign halt       = halt_q;
    assign leds       = leds_q;

endmodule

// File: tb/tb_dual_io_uart_arbiter.sv
// Directed-vector bench for dual_io_uart_arbiter; expected values are hand-derived.
module tb_dual_io_uart_arbiter;

    localparam int DEPTH   = 8;
    localparam int HOLDOFF = 2;
    localparam logic [31:0] AD_DAT   = 32'h0000_0008;
    localparam logic [31:0] AD_STAT  = 32'h0000_0010;
    localparam logic [31:0] AD_HALT  = 32'h0000_0020;
    localparam logic [31:0] AD_STATS = 32'h0000_0040;
`ifdef UART_ARB_STATS_EN
    localparam logic [31:0] EXP_STATS = 32'd5;
`else
    localparam logic [31:0] EXP_STATS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_io_wr = 1'b0, b_io_wr = 1'b0;
    logic [31:0] a_io_addr = AD_STAT, b_io_addr = AD_STAT;
    logic [31:0] a_io_wdata = '0, b_io_wdata = '0;
    logic [31:0] a_io_rdata, b_io_rdata;
    logic        uart_valid, uart_ready = 1'b1, halt;
    logic [7:0]  uart_data, leds;

    dual_io_uart_arbiter #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_io_wr    (a_io_wr),
        .a_io_addr  (a_io_addr),
        .a_io_wdata (a_io_wdata),
        .a_io_rdata (a_io_rdata),
        .b_io_wr    (b_io_wr),
        .b_io_addr  (b_io_addr),
        .b_io_wdata (b_io_wdata),
        .b_io_rdata (b_io_rdata),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .halt       (halt),
        .leds       (leds)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sq[$];
    int         sc[$];
    always @(negedge clk) if (uart_valid) begin
        sq.push_back(uart_data);
        sc.push_back(cyc);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < sq.size()) return sq[i];
        return 8'hxx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input bit lane_b, input logic [31:0] addr, input logic [7:0] d);
        if (lane_b) begin
            b_io_wr = 1'b1; b_io_addr = addr; b_io_wdata = {24'h0, d};
        end else begin
            a_io_wr = 1'b1; a_io_addr = addr; a_io_wdata = {24'h0, d};
        end
        step();
        a_io_wr = 1'b0; b_io_wr = 1'b0;
        a_io_addr = AD_STAT; b_io_addr = AD_STAT;
    endtask

    task automatic wr2(input logic [7:0] da, input logic [7:0] db);
        a_io_wr = 1'b1; a_io_addr = AD_DAT; a_io_wdata = {24'h0, da};
        b_io_wr = 1'b1; b_io_addr = AD_DAT; b_io_wdata = {24'h0, db};
        step();
        a_io_wr = 1'b0; b_io_wr = 1'b0;
        a_io_addr = AD_STAT; b_io_addr = AD_STAT;
    endtask

    task automatic rd_chk(input string tag, input bit lane_b, input logic [31:0] addr,
                          input logic [31:0] exp);
        if (lane_b) b_io_addr = addr; else a_io_addr = addr;
        #1;
        check_vec(tag, lane_b ? b_io_rdata : a_io_rdata, exp);
        a_io_addr = AD_STAT; b_io_addr = AD_STAT;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    int  hcyc, hstrobes;
    bit  found;

    initial begin
        // reset state
        run(2);
        check_vec("rst_valid", uart_valid, 1'b0);
        check_vec("rst_data",  uart_data, 8'h00);
        check_vec("rst_halt",  halt, 1'b0);
        check_vec("rst_leds",  leds, 8'h00);
        rd_chk("rst_status", 1'b0, AD_STAT, 32'h0000_0001);
        rd_chk("rst_stats",  1'b1, AD_STATS, 32'h0);
        reset = 1'b0;
        step();

        // 1: single lane-A char, strobe two cycles after the push cycle
        uart_ready = 1'b1;
        sq.delete(); sc.delete();
        wr(1'b0, AD_DAT, 8'h48);
        check_vec("t1_early", uart_valid, 1'b0);
        step();
        check_vec("t1_valid", uart_valid, 1'b1);
        check_vec("t1_data",  uart_data, 8'h48);
        check_vec("t1_leds",  leds, 8'h48);
        step();
        check_vec("t1_pulse", uart_valid, 1'b0);
        run(10);

        // lane B alone must send lane B's data
        sq.delete(); sc.delete();
        wr(1'b1, AD_DAT, 8'h7A);
        run(12);
        check_vec("tb_count", sq.size(), 1);
        check_vec("tb_data",  q_at(0), 8'h7A);
        check_vec("tb_leds",  leds, 8'h7A);

        // 2: same-cycle A and B, A first
        sq.delete(); sc.delete();
        wr2(8'h61, 8'h62);
        check_vec("t2_leds", leds, 8'h62);
        run(30);
        check_vec("t2_count", sq.size(), 2);
        check_vec("t2_first", q_at(0), 8'h61);
        check_vec("t2_second", q_at(1), 8'h62);
        check_vec("t2_gap", (sc.size() == 2) && (sc[1] - sc[0] >= HOLDOFF + 1), 1'b1);

        // 3: fill to DEPTH-1, then a dual write overflows by one
        uart_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) wr(1'b0, AD_DAT, 8'h30 + 8'(i));
        rd_chk("t3_pre_status", 1'b0, AD_STAT, 32'h0000_0000);
        wr2(8'h78, 8'h79);
        rd_chk("t3_status_a", 1'b0, AD_STAT, 32'h0000_0202);
        rd_chk("t3_status_b", 1'b1, AD_STAT, 32'h0000_0202);
        check_vec("t3_leds", leds, 8'h78);
        sq.delete(); sc.delete();
        uart_ready = 1'b1;
        run(80);
        check_vec("t3_count", sq.size(), DEPTH);
        check_vec("t3_first", q_at(0), 8'h30);
        check_vec("t3_7th",   q_at(DEPTH - 2), 8'h36);
        check_vec("t3_last",  q_at(DEPTH - 1), 8'h78);
        rd_chk("t3_drained", 1'b0, AD_STAT, 32'h0000_0003);

        // 4: halt waits for the buffered characters to leave
        uart_ready = 1'b0;
        wr(1'b0, AD_DAT, 8'h41);
        wr(1'b0, AD_DAT, 8'h42);
        wr(1'b0, AD_DAT, 8'h43);
        wr(1'b1, AD_HALT, 8'h00);
        run(3);
        check_vec("t4_halt_held", halt, 1'b0);
        sq.delete(); sc.delete();
        hcyc = -1; hstrobes = -1;
        uart_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (halt && hcyc < 0) begin
                hcyc = cyc;
                hstrobes = sq.size();
            end
        end
        check_vec("t4_strobes_at_halt", hstrobes, 3);
        check_vec("t4_halt_delay", (sc.size() == 3) ? hcyc - sc[2] : -1, HOLDOFF + 3);
        check_vec("t4_halt_sticky", halt, 1'b1);

        // 5: reset while in HOLD with 4 entries left
        uart_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(1'b0, AD_DAT, 8'h50 + 8'(i));
        uart_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (uart_valid) found = 1'b1;
        end
        check_vec("t5_send_seen", found, 1'b1);
        step();
        #1 reset = 1'b1;
        #1;
        check_vec("t5_valid", uart_valid, 1'b0);
        check_vec("t5_data",  uart_data, 8'h00);
        check_vec("t5_halt",  halt, 1'b0);
        check_vec("t5_leds",  leds, 8'h00);
        rd_chk("t5_status", 1'b0, AD_STAT, 32'h0000_0001);
        run(2);
        reset = 1'b0;
        sq.delete(); sc.delete();
        run(30);
        check_vec("t5_quiet", sq.size(), 0);
        wr(1'b0, AD_DAT, 8'h5A);
        run(10);
        check_vec("t5_new_count", sq.size(), 1);
        check_vec("t5_new_data",  q_at(0), 8'h5A);

        // 6: sent-character counter
        do_reset();
        sq.delete(); sc.delete();
        for (int i = 0; i < 5; i++) wr(i[0], AD_DAT, 8'h31 + 8'(i));
        run(60);
        check_vec("t6_sent", sq.size(), 5);
        rd_chk("t6_stats_a", 1'b0, AD_STATS, EXP_STATS);
        rd_chk("t6_stats_b", 1'b1, AD_STATS, EXP_STATS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
